snoop_bus: RTL and testbench

Shared snooping bus and memory controller that sits directly downstream of the per-processor MESI cache blocks. It arbitrates among N_CPU requesting caches and drives each cache's controleP/habilita so that exactly one cache issues at a time while all others snoop. It latches the issuer's 10-bit bus_out message, broadcasts it on bus_in, and ORs the snoopers' shared_out into shared_in. It then services the memory half of the message against a small backing memory indexed by tag.

---
 rtl/snoop_bus_pkg.sv | 40 ++++
 rtl/bus_arbiter.sv | 42 ++++
 rtl/snoop_bus.sv | 207 ++++++++++++++++++++
 tb/tb_snoop_bus.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus_pkg
// Description : Shared types and constants for the snooping bus controller:
//               FSM state encoding, bus message field positions, memory
//               operation codes and a helper that spots the null message.
// Revision    : 1.0 - initial release
// ============================================================================
package snoop_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        SNOOP = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int MSG_W      = 10;
    localparam int BUS_MSG_HI = 9;
    localparam int BUS_MSG_LO = 8;
    localparam int MEM_MSG_HI = 7;
    localparam int MEM_MSG_LO = 6;
    localparam int TAG_HI     = 5;
    localparam int TAG_LO     = 3;
    localparam int DATA_HI    = 2;
    localparam int DATA_LO    = 0;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_READ = 2'b01;
    localparam logic [1:0] MEM_WB   = 2'b10;

    // A message with neither a bus nor a memory operation needs no snoop
    // phase and no memory access.
    function automatic logic is_null_msg(input logic [MSG_W-1:0] msg);
        return (msg[BUS_MSG_HI:MEM_MSG_LO] == 4'b0000);
    endfunction

endpackage : snoop_bus_pkg
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : One-hot grant generator for the snooping bus.
//               Macro RR_ARB_EN selects round-robin (search starts at ptr);
//               otherwise fixed priority, lowest index wins, ptr ignored.
// Ports       : req   [N_CPU-1:0] in  - request vector
//               ptr   [PTR_W-1:0] in  - round-robin search start index
//               grant [N_CPU-1:0] out - one-hot winner (zero if no request)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int N_CPU = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_CPU-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_CPU-1:0] grant
);

`ifdef RR_ARB_EN
    // Rotate requests so ptr lands at bit 0, isolate the lowest set bit,
    // then rotate the one-hot result back into place.
    logic [2*N_CPU-1:0] w_req_dbl;
    logic [2*N_CPU-1:0] w_gnt_dbl;
    logic [N_CPU-1:0]   w_req_rot;
    logic [N_CPU-1:0]   w_gnt_rot;

    assign w_req_dbl = {req, req} >> ptr;
    assign w_req_rot = w_req_dbl[N_CPU-1:0];
    assign w_gnt_rot = w_req_rot & (~w_req_rot + N_CPU'(1));
    assign w_gnt_dbl = {{N_CPU{1'b0}}, w_gnt_rot} << ptr;
    assign grant     = w_gnt_dbl[2*N_CPU-1:N_CPU] | w_gnt_dbl[N_CPU-1:0];
`else
    logic w_unused_ptr;

    assign w_unused_ptr = ^ptr;
    assign grant        = req & (~req + N_CPU'(1));
`endif

endmodule : bus_arbiter
`default_nettype wire

// File: rtl/snoop_bus.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus
// Description : Snooping bus + backing-memory controller for MESI caches.
//               Arbitrates one issuer, latches and broadcasts its message,
//               collects snoop responses and services the memory half.
//               Macro RR_ARB_EN: round-robin arbitration (else fixed prio).
// Ports       : clock, clear (async, active low)
//               req, msg_in, shared_out_i       - from the caches
//               controleP, habilita, bus_in,
//               shared_in, grant                - to the caches
//               mem_data, busy, done            - status / read data
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus
    import snoop_bus_pkg::*;
#(
    parameter int N_CPU        = 3,
    parameter int ISSUE_CYCLES = 3,
    parameter int SNOOP_CYCLES = 2,
    parameter int MEM_WORDS    = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_CPU-1:0]       req,
    input  logic [MSG_W*N_CPU-1:0] msg_in,
    input  logic [N_CPU-1:0]       shared_out_i,
    output logic [N_CPU-1:0]       controleP,
    output logic [N_CPU-1:0]       habilita,
    output logic [MSG_W-1:0]       bus_in,
    output logic                   shared_in,
    output logic [N_CPU-1:0]       grant,
    output logic [2:0]             mem_data,
    output logic                   busy,
    output logic                   done
);

    localparam int PTR_W  = $clog2(N_CPU);
    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W  = 8;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_CPU-1:0]    r_grant;
    logic [N_CPU-1:0]    w_arb_grant;
    logic [MSG_W-1:0]    r_bus;
    logic                r_shared;
    logic [2:0]          r_mem_data;
    logic [2:0]          r_mem [MEM_WORDS];
    logic [MSG_W-1:0]    w_msg_sel;
    logic [PTR_W-1:0]    w_ptr;
    logic [MEM_AW-1:0]   w_mem_idx;
    logic                w_issue_last;
    logic                w_snoop_last;

    assign w_issue_last = (r_cnt == CNT_W'(ISSUE_CYCLES - 1));
    assign w_snoop_last = (r_cnt == CNT_W'(SNOOP_CYCLES - 1));
    assign w_mem_idx    = MEM_AW'(32'(r_bus[TAG_HI:TAG_LO]) % MEM_WORDS);

    bus_arbiter #(
        .N_CPU (N_CPU),
        .PTR_W (PTR_W)
    ) u_arbiter (
        .req   (req),
        .ptr   (w_ptr),
        .grant (w_arb_grant)
    );

`ifdef RR_ARB_EN
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_win_idx;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (w_arb_grant[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    // Pointer moves to the CPU after the winner as the grant is taken.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && |req) begin
            r_ptr <= (w_win_idx == PTR_W'(N_CPU - 1)) ? '0 : w_win_idx + PTR_W'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Issuer's message, selected by the registered one-hot grant.
    always_comb begin
        w_msg_sel = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (r_grant[i]) begin
                w_msg_sel = w_msg_sel | msg_in[i*MSG_W +: MSG_W];
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        controleP   = '0;
        habilita    = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                controleP = r_grant;
                habilita  = '1;
                if (w_issue_last) begin
                    w_state_nxt = SNOOP;
                end
            end
            SNOOP: begin
                habilita = '1;
                // The latched message is first visible here, so the null
                // shortcut is taken from the first snoop cycle.
                if (r_cnt == '0 && is_null_msg(r_bus)) begin
                    w_state_nxt = DONE;
                end else if (w_snoop_last) begin
                    w_state_nxt = MEM;
                end
            end
            MEM: begin
                habilita    = '1;
                w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_cnt      <= '0;
            r_grant    <= '0;
            r_bus      <= '0;
            r_shared   <= 1'b0;
            r_mem_data <= '0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (r_state != w_state_nxt) begin
                r_cnt <= '0;
            end else if (r_state == ISSUE || r_state == SNOOP) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == IDLE && |req) begin
                r_grant <= w_arb_grant;
            end else if (r_state == DONE) begin
                r_grant <= '0;
            end

            if (r_state == ISSUE && w_issue_last) begin
                r_bus <= w_msg_sel;
            end

            // The issuer never answers its own snoop.
            if (r_state == SNOOP && w_state_nxt == MEM) begin
                r_shared <= |(shared_out_i & ~r_grant);
            end

            if (r_state == MEM) begin
                case (r_bus[MEM_MSG_HI:MEM_MSG_LO])
                    MEM_READ: r_mem_data       <= r_mem[w_mem_idx];
                    MEM_WB:   r_mem[w_mem_idx] <= r_bus[DATA_HI:DATA_LO];
                    default:  ;
                endcase
            end
        end
    end

    assign bus_in    = r_bus;
    assign shared_in = r_shared;
    assign grant     = r_grant;
    assign mem_data  = r_mem_data;

endmodule : snoop_bus
`default_nettype wire

// File: tb/tb_snoop_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_bus
// Description : Self-checking bench for snoop_bus. Stimulus pushes the
//               expected transaction result into a queue; a monitor pops and
//               compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus;

    localparam int N = 3;

    typedef struct {
        logic [2:0] g;
        logic [9:0] bus;
        logic       sh;
        logic [2:0] md;
        int         lat;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic [N-1:0] req   = '0;
    logic [9:0]   m0 = '0, m1 = '0, m2 = '0;
    logic [N-1:0] shared_out_i = '0;
    logic [N-1:0] controleP, habilita, grant;
    logic [9:0]   bus_in;
    logic         shared_in, busy, done;
    logic [2:0]   mem_data;

    exp_t q[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   cp_cnt = 0;
    logic hab_bad = 1'b0;

    always #5 clock = ~clock;

    snoop_bus #(
        .N_CPU        (3),
        .ISSUE_CYCLES (3),
        .SNOOP_CYCLES (2),
        .MEM_WORDS    (8)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .req          (req),
        .msg_in       ({m2, m1, m0}),
        .shared_out_i (shared_out_i),
        .controleP    (controleP),
        .habilita     (habilita),
        .bus_in       (bus_in),
        .shared_in    (shared_in),
        .grant        (grant),
        .mem_data     (mem_data),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input logic [2:0] g, input logic [9:0] bus, input logic sh,
                        input logic [2:0] md, input int lat);
        exp_t e;
        e.g = g; e.bus = bus; e.sh = sh; e.md = md; e.lat = lat;
        q.push_back(e);
    endtask

    // Monitor / scoreboard.
    always @(negedge clock) begin
        cyc++;
        if (!clear) begin
            cp_cnt  = 0;
            hab_bad = 1'b0;
        end else begin
            if (!busy && req != '0) begin
                t_start = cyc;
                cp_cnt  = 0;
                hab_bad = 1'b0;
            end
            if (controleP != '0) begin
                cp_cnt++;
                if (controleP !== grant || habilita !== 3'b111) hab_bad = 1'b1;
            end
            if (done) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got done=1 required no transaction pending (t=%0t)", $time);
                end else begin
                    m_e = q.pop_front();
                    chk("grant", 32'(grant), 32'(m_e.g));
                    chk("bus_in", 32'(bus_in), 32'(m_e.bus));
                    chk("shared_in", 32'(shared_in), 32'(m_e.sh));
                    chk("mem_data", 32'(mem_data), 32'(m_e.md));
                    chk("latency", 32'(cyc - t_start), 32'(m_e.lat));
                    chk("issue_cycles", 32'(cp_cnt), 32'd3);
                    chk("issue_ctrl", 32'(hab_bad), 32'd0);
                    chk("done_ctrl", 32'({controleP, habilita}), 32'd0);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_controleP"}, 32'(controleP), 32'd0);
        chk({tag, "_habilita"}, 32'(habilita), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_bus_in"}, 32'(bus_in), 32'd0);
        chk({tag, "_shared_in"}, 32'(shared_in), 32'd0);
        chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_done();
        int b = 0;
        do begin
            @(negedge clock);
            b++;
        end while (!done && b < 60);
        if (!done) begin
            n_chk++;
            $display("FAIL done_timeout: got no done in %0d cycles required done", b);
        end
        #1;
    endtask

    task automatic txn(input logic [N-1:0] r, input int n);
        @(posedge clock);
        #2 req = r;
        for (int k = 0; k < n; k++) wait_done();
        req = '0;
    endtask

    logic [2:0] md_f;

    initial begin
        #12 check_zero("reset");
        @(negedge clock);
        #1 clear = 1'b1;

        // Single read miss
        m0 = 10'h168; shared_out_i = 3'b110;
        push(3'b001, 10'h168, 1'b1, 3'd0, 7);
        txn(3'b001, 1);

        // Write-back of 110 to tag 3
        m1 = 10'h09E; shared_out_i = 3'b000;
        push(3'b010, 10'h09E, 1'b0, 3'd0, 7);
        txn(3'b010, 1);

        // Issuer exclusion: only the issuer raises shared_out
        m1 = 10'h158; shared_out_i = 3'b010;
        push(3'b010, 10'h158, 1'b0, 3'b110, 7);
        txn(3'b010, 1);

        // Read back tag 3 from CPU2
        m2 = 10'h158; shared_out_i = 3'b000;
        push(3'b100, 10'h158, 1'b0, 3'b110, 7);
        txn(3'b100, 1);

        // Simultaneous requests held for three transactions
        m0 = 10'h309; m1 = 10'h1AF; m2 = 10'h168;
`ifdef RR_ARB_EN
        push(3'b001, 10'h309, 1'b0, 3'b110, 7);
        push(3'b010, 10'h1AF, 1'b0, 3'b110, 7);
        push(3'b100, 10'h168, 1'b0, 3'b111, 7);
        md_f = 3'b111;
`else
        push(3'b001, 10'h309, 1'b0, 3'b110, 7);
        push(3'b001, 10'h309, 1'b0, 3'b110, 7);
        push(3'b001, 10'h309, 1'b0, 3'b110, 7);
        md_f = 3'b000;
`endif
        txn(3'b111, 3);

        // Read tag 5 with a snoop hit, leaving shared_in = 1
        m0 = 10'h168; shared_out_i = 3'b110;
        push(3'b001, 10'h168, 1'b1, md_f, 7);
        txn(3'b001, 1);

        // Null message: short path, shared_in and mem_data hold
        m0 = 10'h000; shared_out_i = 3'b111;
        push(3'b001, 10'h000, 1'b1, md_f, 5);
        txn(3'b001, 1);

        // Tag 5 unchanged
        m0 = 10'h168; shared_out_i = 3'b000;
        push(3'b001, 10'h168, 1'b0, md_f, 7);
        txn(3'b001, 1);

        // Write 101 to tag 2
        m0 = 10'h095;
        push(3'b001, 10'h095, 1'b0, md_f, 7);
        txn(3'b001, 1);

        // Reset during SNOOP
        m1 = 10'h168;
        @(posedge clock);
        #2 req = 3'b010;
        begin
            int b = 0;
            do begin
                @(negedge clock);
                b++;
            end while (!(busy && controleP == '0 && habilita != '0) && b < 20);
            chk("reach_snoop", 32'(busy && controleP == '0 && habilita != '0), 32'd1);
        end
        #1 clear = 1'b0;
        req = '0;
        #1 check_zero("abort");
        @(posedge clock);
        #2 clear = 1'b1;

        // Fresh transaction: tag 2 must read back cleared
        m0 = 10'h150; shared_out_i = 3'b010;
        push(3'b001, 10'h150, 1'b1, 3'd0, 7);
        txn(3'b011, 1);

        repeat (3) @(negedge clock);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test required finish");
        $fatal(1, "timeout");
    end

endmodule : tb_snoop_bus
`default_nettype wire
